// File: rtl/aes_inv_key_schedule.sv
// AES-128 round keys for the decryption datapath, delivered round 10 down to round 0.
// Latency: 1 cycle from an accepted start with the round-10 key, 11 cycles with the cipher key.
// Backpressure: key_valid/key_ready handshake; key_out/key_round hold while stalled.
module aes_inv_key_schedule #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         key_is_last,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic [3:0]   key_round
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   round_q, round_d;

  logic [31:0]  w0, w1, w2, w3, v3;
  logic [31:0]  sb_in, sb_out, t;
  logic [3:0]   rc_idx;
  logic [127:0] fwd_key, inv_key;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Shared SubWord datapath: forward step uses w3, inverse step uses w3^w2.
  always_comb begin
    w0      = key_q[127:96];
    w1      = key_q[95:64];
    w2      = key_q[63:32];
    w3      = key_q[31:0];
    v3      = w3 ^ w2;
    sb_in   = (state_q == S_STREAM) ? {v3[23:0], v3[31:24]} : {w3[23:0], w3[31:24]};
    rc_idx  = (state_q == S_STREAM) ? (round_q - 4'd1) : cnt_q;
    t       = sb_out ^ {rcon(rc_idx), 24'h000000};
    fwd_key[127:96] = w0 ^ t;
    fwd_key[95:64]  = w1 ^ fwd_key[127:96];
    fwd_key[63:32]  = w2 ^ fwd_key[95:64];
    fwd_key[31:0]   = w3 ^ fwd_key[63:32];
    inv_key = {w0 ^ t, w1 ^ w0, w2 ^ w1, v3};
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sb_in[8*g +: 8]),
      .c (sb_out[8*g +: 8])
    );
  end

  // Next-state: load, expand forward to round 10, then step backwards per handshake.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d = key_in;
          cnt_d = 4'd0;
          if (key_is_last) begin
            state_d = S_STREAM;
            round_d = 4'(ROUNDS);
          end else begin
            state_d = S_EXPAND;
          end
        end
      end
      S_EXPAND: begin
        key_d = fwd_key;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ROUNDS - 1)) begin
          state_d = S_STREAM;
          round_d = 4'(ROUNDS);
        end
      end
      S_STREAM: begin
        if (key_ready) begin
          if (round_q == 4'd0) begin
            state_d = S_IDLE;
          end else begin
            key_d   = inv_key;
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign key_valid = (state_q == S_STREAM);
  assign key_out   = key_q;
  assign key_round = round_q;

endmodule

// AES S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
// Latency: combinational.
// Backpressure: none.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);

  logic [7:0] inv;

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] b;
    p = 8'h00;
    b = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ b;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  // Inverse then affine transform.
  always_comb begin
    inv = ginv(a);
    c   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: reference schedule from a word-wise AES-128
// expansion with a brute-force S-box, checked against known vectors and random keys.
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         key_is_last;
  logic [127:0] key_in;
  logic         busy;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_out;
  logic [3:0]   key_round;

  always #5 clk = ~clk;

  aes_inv_key_schedule #(.ROUNDS(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .key_is_last (key_is_last),
    .key_in      (key_in),
    .busy        (busy),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_out     (key_out),
    .key_round   (key_round)
  );

  typedef struct {
    int           round;
    logic [127:0] key;
  } vec_t;

  localparam logic [127:0] CIPHER_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [7:0]   sbox_tb [0:255];
  logic [127:0] model_rk [0:10];
  logic [127:0] got_rk [0:10];
  vec_t         vecs [0:3];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul_tb(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] aa;
    logic [7:0] bb;
    logic [7:0] acc;
    aa  = a;
    bb  = b;
    acc = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) acc = acc ^ aa;
      bb = bb >> 1;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return acc;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] cst;
    logic [7:0] o;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul_tb(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sbox_tb[x] = o;
    end
  endtask

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox_tb[r[31:24]], sbox_tb[r[23:16]], sbox_tb[r[15:8]], sbox_tb[r[7:0]]};
  endfunction

  // Full forward expansion into 44 words, then grouped into round keys.
  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = sub_rot(tmp) ^ {rc, 24'h0};
        rc  = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k, input logic last);
    start       = 1'b1;
    key_is_last = last;
    key_in      = k;
    step();
    start       = 1'b0;
    key_is_last = 1'($urandom);
    key_in      = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Counts edges from the start-sampling edge (edge 1) until key_valid rises.
  task automatic wait_valid(input string name, input int exp_edges, input bit noise);
    int n;
    n = 1;
    while (!key_valid && n < 40) begin
      if (noise) begin
        start       = 1'($urandom);
        key_is_last = 1'($urandom);
        key_in      = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
      n++;
    end
    start = 1'b0;
    chk({name, " latency"}, 128'(n), 128'(exp_edges));
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0 per valid cycle, 2: random ready.
  task automatic collect(input string name, input int mode, input bit noise);
    int           exp_r;
    int           hs;
    int           cyc;
    int           pat;
    bit           stalled;
    logic [127:0] hk;
    logic [3:0]   hr;
    exp_r   = 10;
    hs      = 0;
    cyc     = 0;
    pat     = 0;
    stalled = 1'b0;
    hk      = '0;
    hr      = '0;
    while (hs < 11 && cyc < 200) begin
      if (stalled) begin
        chk({name, " stall valid"}, 128'(key_valid), 128'(1));
        chk({name, " stall key"}, key_out, hk);
        chk({name, " stall round"}, 128'(key_round), 128'(hr));
      end
      case (mode)
        0:       key_ready = 1'b1;
        1:       key_ready = (pat % 3 == 0);
        default: key_ready = 1'($urandom);
      endcase
      if (noise) begin
        start       = 1'($urandom);
        key_is_last = 1'($urandom);
        key_in      = {$urandom, $urandom, $urandom, $urandom};
      end
      stalled = 1'b0;
      if (key_valid) begin
        pat++;
        if (key_ready) begin
          chk({name, " round"}, 128'(key_round), 128'(exp_r));
          chk({name, " key"}, key_out, model_rk[exp_r]);
          got_rk[exp_r] = key_out;
          exp_r--;
          hs++;
        end else begin
          stalled = 1'b1;
          hk      = key_out;
          hr      = key_round;
        end
      end
      step();
      cyc++;
    end
    start     = 1'b0;
    key_ready = 1'b0;
    chk({name, " handshakes"}, 128'(hs), 128'(11));
    chk({name, " valid after r0"}, 128'(key_valid), 128'(0));
    chk({name, " busy after r0"}, 128'(busy), 128'(0));
  endtask

  task automatic check_table(input string name);
    for (int i = 0; i < 4; i++)
      chk({name, " vector"}, got_rk[vecs[i].round], vecs[i].key);
  endtask

  initial begin
    logic [127:0] rk;
    logic         last;
    rst         = 1'b1;
    start       = 1'b0;
    key_is_last = 1'b0;
    key_in      = '0;
    key_ready   = 1'b0;

    vecs[0] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[2] = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[3] = '{0,  CIPHER_KEY};

    build_sbox();
    step();
    step();
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset valid", 128'(key_valid), 128'(0));
    chk("reset key_out", key_out, 128'(0));
    chk("reset key_round", 128'(key_round), 128'(0));
    rst = 1'b0;

    compute_model(CIPHER_KEY);
    for (int i = 0; i < 4; i++) chk("model vector", model_rk[vecs[i].round], vecs[i].key);
    rk = model_rk[10];

    // Cipher key, expanded in place.
    do_start(CIPHER_KEY, 1'b0);
    chk("t1 busy", 128'(busy), 128'(1));
    wait_valid("t1", 11, 1'b0);
    collect("t1", 0, 1'b0);
    check_table("t1");

    // Round-10 key loaded directly.
    do_start(rk, 1'b1);
    wait_valid("t2", 1, 1'b0);
    collect("t2", 0, 1'b0);
    check_table("t2");

    // Stalls with ready pattern 1,0,0.
    do_start(CIPHER_KEY, 1'b0);
    wait_valid("t3", 11, 1'b0);
    collect("t3", 1, 1'b0);
    check_table("t3");

    // Spurious starts during EXPAND and STREAM.
    do_start(CIPHER_KEY, 1'b0);
    wait_valid("t4", 11, 1'b1);
    collect("t4", 0, 1'b1);
    check_table("t4");

    // Reset mid-EXPAND, then reload with the round-10 key.
    do_start(CIPHER_KEY, 1'b0);
    repeat (4) step();
    chk("t5 busy before rst", 128'(busy), 128'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5 busy", 128'(busy), 128'(0));
    chk("t5 valid", 128'(key_valid), 128'(0));
    chk("t5 key_out", key_out, 128'(0));
    chk("t5 key_round", 128'(key_round), 128'(0));
    do_start(rk, 1'b1);
    wait_valid("t5", 1, 1'b0);
    collect("t5", 0, 1'b0);

    // Start in the IDLE cycle right after the round-0 handshake.
    do_start(rk, 1'b1);
    wait_valid("t6a", 1, 1'b0);
    collect("t6a", 2, 1'b0);
    check_table("t6a");
    do_start(CIPHER_KEY, 1'b0);
    wait_valid("t6b", 11, 1'b0);
    collect("t6b", 0, 1'b0);
    check_table("t6b");

    // Random keys, random load mode, random backpressure.
    for (int it = 0; it < 6; it++) begin
      rk   = {$urandom, $urandom, $urandom, $urandom};
      last = 1'($urandom);
      compute_model(rk);
      do_start(last ? model_rk[10] : rk, last);
      wait_valid("rnd", last ? 1 : 11, 1'($urandom));
      collect("rnd", 2, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
